// File: rtl/t06_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : t06_game_state_ctrl
// Description : Game-flow controller. It detects button edges internally and
//               tracks lives, score and a win condition. It also times the
//               respawn period and, optionally, an automatic return from
//               GAMEOVER/WIN to IDLE.
//               It sits between the input-sync/collision logic and the
//               display/scoring blocks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1        system clock, rising edge
//   nrst          in   1        asynchronous active-low reset
//   button        in   1        synchronised level: start/pause/resume/ack
//   badCollision  in   1        one-cycle pulse, fatal hit
//   goodCollision in   1        one-cycle pulse, item collected (+1 score)
//   state         out  3        0 IDLE,1 RUN,2 PAUSE,3 RESPAWN,4 GAMEOVER,5 WIN
//   lives         out  LIVES_W  remaining lives
//   score         out  SCORE_W  current score
//   new_game      out  1        one-cycle pulse on IDLE->RUN
//   life_lost     out  1        one-cycle pulse on every accepted badCollision
// ============================================================================
module t06_game_state_ctrl #(
    parameter int LIVES          = 3,
    parameter int LIVES_W        = 2,
    parameter int SCORE_W        = 8,
    parameter int WIN_SCORE      = 50,
    parameter int RESPAWN_CYCLES = 16,
    parameter int HOLD_CYCLES    = 0
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               button,
    input  logic               badCollision,
    input  logic               goodCollision,
    output logic [2:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               new_game,
    output logic               life_lost
);

    // Timer is sized for the longest countdown it has to hold. It is at least
    // one bit wide so that the register never collapses to zero width.
    localparam int c_tmax_rh = (RESPAWN_CYCLES > HOLD_CYCLES) ? RESPAWN_CYCLES : HOLD_CYCLES;
    localparam int c_tmax    = (c_tmax_rh > 2) ? c_tmax_rh : 2;
    localparam int c_timer_w = $clog2(c_tmax);

    // Countdown loads are "cycles - 1": the state exits on the edge where the
    // timer is already zero, giving exactly N cycles of residency.
    localparam logic [c_timer_w-1:0] c_respawn_load = c_timer_w'(RESPAWN_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_hold_load    =
        (HOLD_CYCLES == 0) ? '0 : c_timer_w'(HOLD_CYCLES - 1);
    localparam logic [LIVES_W-1:0]   c_lives_init   = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0]   c_win_score    = SCORE_W'(WIN_SCORE);
    localparam logic                 c_hold_en      = (HOLD_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PAUSE    = 3'd2,
        ST_RESPAWN  = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } state_t;

    state_t               state_q,     state_d;
    logic [LIVES_W-1:0]   lives_q,     lives_d;
    logic [SCORE_W-1:0]   score_q,     score_d;
    logic [c_timer_w-1:0] timer_q,     timer_d;
    logic                 new_game_q,  new_game_d;
    logic                 life_lost_q, life_lost_d;
    logic                 btn_q,       btn_d;

    logic                 w_press;
    logic [SCORE_W-1:0]   w_score_inc;
    logic                 w_timer_zero;

    // Rising edge of the button level. btn_q resets high so a button held
    // through reset is not mistaken for a press.
    assign w_press      = button & ~btn_q;
    assign w_score_inc  = score_q + SCORE_W'(1);
    assign w_timer_zero = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        timer_d     = timer_q;
        new_game_d  = 1'b0;
        life_lost_d = 1'b0;
        btn_d       = button;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (w_press) begin
                    state_d    = ST_RUN;
                    lives_d    = c_lives_init;
                    score_d    = '0;
                    new_game_d = 1'b1;
                end
            end

            ST_RUN: begin
                timer_d = '0;
                // One event per cycle: a fatal hit masks a simultaneous
                // pickup, and both mask the button.
                if (badCollision) begin
                    life_lost_d = 1'b1;
                    lives_d     = lives_q - LIVES_W'(1);
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = ST_GAMEOVER;
                        timer_d = c_hold_load;
                    end else begin
                        state_d = ST_RESPAWN;
                        timer_d = c_respawn_load;
                    end
                end else if (goodCollision) begin
                    score_d = w_score_inc;
                    // Leaving RUN at WIN_SCORE is what keeps score from ever
                    // wrapping.
                    if (w_score_inc == c_win_score) begin
                        state_d = ST_WIN;
                        timer_d = c_hold_load;
                    end
                end else if (w_press) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                timer_d = '0;
                if (w_press) begin
                    state_d = ST_RUN;
                end
            end

            ST_RESPAWN: begin
                if (w_timer_zero) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q - c_timer_w'(1);
                end
            end

            ST_GAMEOVER, ST_WIN: begin
                // Press and hold expiry in the same cycle both lead to IDLE,
                // so they collapse into a single transition.
                if (w_press || (c_hold_en && w_timer_zero)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (c_hold_en) begin
                    timer_d = timer_q - c_timer_w'(1);
                end
            end

            default: begin
                // Encodings 6 and 7 are unreachable in normal operation.
                // Recover to IDLE.
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            lives_q     <= c_lives_init;
            score_q     <= '0;
            timer_q     <= '0;
            new_game_q  <= 1'b0;
            life_lost_q <= 1'b0;
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            timer_q     <= timer_d;
            new_game_q  <= new_game_d;
            life_lost_q <= life_lost_d;
            btn_q       <= btn_d;
        end
    end

    assign state     = state_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign new_game  = new_game_q;
    assign life_lost = life_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_t06_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_t06_game_state_ctrl
// Description : Self-checking bench for t06_game_state_ctrl. It runs two
//               instances on shared stimulus, one with no hold timer and one
//               with an 8-cycle hold. Directed scenarios are followed by a
//               randomized run that is checked against a cycle-level game
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t06_game_state_ctrl;

    localparam int LIVES   = 3;
    localparam int WIN     = 50;
    localparam int RESPAWN = 16;
    localparam int HOLD1   = 8;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_RESPAWN = 3,
                   S_GAMEOVER = 4, S_WIN = 5;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       button = 1'b1;
    logic       bad = 1'b0;
    logic       good = 1'b0;

    logic [2:0] st0, st1;
    logic [1:0] lv0, lv1;
    logic [7:0] sc0, sc1;
    logic       ng0, ng1, ll0, ll1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    t06_game_state_ctrl #(.HOLD_CYCLES(0)) dut0 (
        .clk(clk), .nrst(nrst), .button(button),
        .badCollision(bad), .goodCollision(good),
        .state(st0), .lives(lv0), .score(sc0),
        .new_game(ng0), .life_lost(ll0)
    );

    t06_game_state_ctrl #(.HOLD_CYCLES(HOLD1)) dut1 (
        .clk(clk), .nrst(nrst), .button(button),
        .badCollision(bad), .goodCollision(good),
        .state(st1), .lives(lv1), .score(sc1),
        .new_game(ng1), .life_lost(ll1)
    );

    // ------------------------------------------------------------------
    // Game model: "left" counts the cycles still to be spent in a timed
    // state. Entering a timed state sets it to the full duration.
    // ------------------------------------------------------------------
    typedef struct packed {
        int st;
        int lives;
        int score;
        int left;
        bit prev;
        bit ng;
        bit ll;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.st = S_IDLE; m.lives = LIVES; m.score = 0; m.left = 0;
        m.prev = 1'b1; m.ng = 1'b0; m.ll = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit btn, bit b, bit g, int hold);
        model_t n = m;
        bit press = btn && !m.prev;
        n.prev = btn;
        n.ng   = 1'b0;
        n.ll   = 1'b0;
        if (m.st == S_IDLE) begin
            if (press) begin
                n.st = S_RUN; n.lives = LIVES; n.score = 0; n.ng = 1'b1;
            end
        end else if (m.st == S_RUN) begin
            if (b) begin
                n.lives = m.lives - 1;
                n.ll    = 1'b1;
                if (n.lives == 0) begin n.st = S_GAMEOVER; n.left = hold; end
                else              begin n.st = S_RESPAWN;  n.left = RESPAWN; end
            end else if (g) begin
                n.score = m.score + 1;
                if (n.score == WIN) begin n.st = S_WIN; n.left = hold; end
            end else if (press) begin
                n.st = S_PAUSE;
            end
        end else if (m.st == S_PAUSE) begin
            if (press) n.st = S_RUN;
        end else if (m.st == S_RESPAWN) begin
            n.left = m.left - 1;
            if (n.left == 0) n.st = S_RUN;
        end else begin
            if (press) n.st = S_IDLE;
            else if (hold != 0) begin
                n.left = m.left - 1;
                if (n.left == 0) n.st = S_IDLE;
            end
        end
        return n;
    endfunction

    model_t m0, m1;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= model_step(m0, button, bad, good, 0);
            m1 <= model_step(m1, button, bad, good, HOLD1);
        end
    end

    // Drive one cycle of inputs at the falling edge. Outputs settle shortly
    // after the following rising edge.
    task automatic cyc(input bit b, input bit bd, input bit gd);
        @(negedge clk);
        button = b; bad = bd; good = gd;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        nrst = 1'b0; button = 1'b1; bad = 1'b0; good = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({st0, lv0, sc0, ng0, ll0} !== {3'd0, 2'd3, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got st=%0d lives=%0d score=%0d ng=%0b ll=%0b, want 0 3 0 0 0",
                     st0, lv0, sc0, ng0, ll0);
        end
        @(negedge clk); nrst = 1'b1;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        n_checks++;
        if (st0 !== 3'd0) begin
            n_fail++;
            $display("FAIL held_button_no_start: got st=%0d want 0", st0);
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        n_checks++;
        if ({st0, ng0, lv0, sc0} !== {3'd1, 1'b1, 2'd3, 8'd0}) begin
            n_fail++;
            $display("FAIL start_game: got st=%0d ng=%0b lives=%0d score=%0d want 1 1 3 0",
                     st0, ng0, lv0, sc0);
        end
        cyc(0, 0, 0);
        n_checks++;
        if ({st0, ng0} !== {3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL new_game_one_cycle: got st=%0d ng=%0b want 1 0", st0, ng0);
        end
    endtask

    task automatic test_pause();
        cyc(1, 0, 0);
        n_checks++;
        if (st0 !== 3'd2) begin
            n_fail++;
            $display("FAIL enter_pause: got st=%0d want 2", st0);
        end
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        n_checks++;
        if ({st0, sc0, lv0, ll0} !== {3'd2, 8'd0, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL pause_ignores_collisions: got st=%0d score=%0d lives=%0d ll=%0b want 2 0 3 0",
                     st0, sc0, lv0, ll0);
        end
        cyc(1, 0, 0);
        n_checks++;
        if (st0 !== 3'd1) begin
            n_fail++;
            $display("FAIL resume: got st=%0d want 1", st0);
        end
        cyc(0, 0, 1);
        n_checks++;
        if (sc0 !== 8'd1) begin
            n_fail++;
            $display("FAIL score_inc: got score=%0d want 1", sc0);
        end
    endtask

    task automatic test_lives();
        int cnt;
        int lost = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0);
            if (ll0 === 1'b1) lost++;
            n_checks++;
            if ({lv0, st0} !== {2'(2 - k), (k < 2) ? 3'd3 : 3'd4}) begin
                n_fail++;
                $display("FAIL hit_%0d: got lives=%0d st=%0d want %0d %0d",
                         k, lv0, st0, 2 - k, (k < 2) ? 3 : 4);
            end
            if (k < 2) begin
                cnt = 0;
                while (st0 === 3'd3 && cnt < 40) begin
                    cnt++;
                    cyc(0, 0, 0);
                    if (ll0 === 1'b1) lost++;
                end
                n_checks++;
                if (cnt !== RESPAWN || st0 !== 3'd1) begin
                    n_fail++;
                    $display("FAIL respawn_len_%0d: got %0d cycles then st=%0d want %0d then 1",
                             k, cnt, st0, RESPAWN);
                end
                repeat (3) cyc(0, 0, 0);
            end
        end
        n_checks++;
        if (lost !== 3) begin
            n_fail++;
            $display("FAIL life_lost_pulses: got %0d want 3", lost);
        end
        // Both instances entered GAMEOVER on the same edge. Only the one
        // with a hold timer returns to IDLE on its own.
        cnt = 0;
        while (st1 === 3'd4 && cnt < 40) begin
            cnt++;
            cyc(0, 0, 0);
        end
        n_checks++;
        if (cnt !== HOLD1 || st1 !== 3'd0) begin
            n_fail++;
            $display("FAIL hold_return: got %0d cycles then st=%0d want %0d then 0", cnt, st1, HOLD1);
        end
        n_checks++;
        if ({st0, lv0} !== {3'd4, 2'd0}) begin
            n_fail++;
            $display("FAIL gameover_stays: got st=%0d lives=%0d want 4 0", st0, lv0);
        end
        cyc(1, 0, 0);
        n_checks++;
        if (st0 !== 3'd0) begin
            n_fail++;
            $display("FAIL gameover_ack: got st=%0d want 0", st0);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_bad_good();
        int cnt = 0;
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        n_checks++;
        if ({st0, lv0, sc0, ll0} !== {3'd3, 2'd2, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_and_good: got st=%0d lives=%0d score=%0d ll=%0b want 3 2 1 1",
                     st0, lv0, sc0, ll0);
        end
        while (st0 !== 3'd1 && cnt < 40) begin
            cnt++;
            cyc(0, 0, 0);
        end
    endtask

    task automatic test_win();
        for (int i = 0; i < WIN - 1; i++) cyc(0, 0, 1);
        n_checks++;
        if ({st0, sc0} !== {3'd5, 8'd50}) begin
            n_fail++;
            $display("FAIL reach_win: got st=%0d score=%0d want 5 50", st0, sc0);
        end
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        n_checks++;
        if ({st0, sc0, lv0, ll0} !== {3'd5, 8'd50, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL win_ignores: got st=%0d score=%0d lives=%0d ll=%0b want 5 50 2 0",
                     st0, sc0, lv0, ll0);
        end
        cyc(1, 0, 0);
        n_checks++;
        if ({st0, sc0, lv0} !== {3'd0, 8'd50, 2'd2}) begin
            n_fail++;
            $display("FAIL win_ack: got st=%0d score=%0d lives=%0d want 0 50 2", st0, sc0, lv0);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({st0, lv0, sc0, ng0, ll0, st1, lv1, sc1} !==
            {3'd0, 2'd3, 8'd0, 1'b0, 1'b0, 3'd0, 2'd3, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d lives=%0d score=%0d ll=%0b / st=%0d lives=%0d score=%0d want 0 3 0 0",
                     st0, lv0, sc0, ll0, st1, lv1, sc1);
        end
        button = 1'b0; bad = 1'b0; good = 1'b0;
        @(negedge clk); nrst = 1'b1;
    endtask

    task automatic test_random();
        bit b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            cyc(b, $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
            n_checks++;
            if ({st0, lv0, sc0, ng0, ll0} !==
                {3'(m0.st), 2'(m0.lives), 8'(m0.score), m0.ng, m0.ll}) begin
                n_fail++;
                $display("FAIL random_hold0 cycle %0d: got st=%0d lives=%0d score=%0d ng=%0b ll=%0b want %0d %0d %0d %0b %0b",
                         i, st0, lv0, sc0, ng0, ll0, m0.st, m0.lives, m0.score, m0.ng, m0.ll);
            end
            n_checks++;
            if ({st1, lv1, sc1, ng1, ll1} !==
                {3'(m1.st), 2'(m1.lives), 8'(m1.score), m1.ng, m1.ll}) begin
                n_fail++;
                $display("FAIL random_hold8 cycle %0d: got st=%0d lives=%0d score=%0d ng=%0b ll=%0b want %0d %0d %0d %0b %0b",
                         i, st1, lv1, sc1, ng1, ll1, m1.st, m1.lives, m1.score, m1.ng, m1.ll);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pause();
        test_lives();
        test_bad_good();
        test_win();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
